// File: rtl/ball_pkg.sv
// ball_pkg: shared types and constants for the ball motion engine.
// Contents: ball state enum, ball colour, serve height offset.
package ball_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        LOST  = 2'd2
    } ball_state_e;

    localparam logic [23:0] BALL_COLOR  = 24'hFFFFFF;
    localparam int unsigned SERVE_Y_OFS = 60;

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// ball_motion_ctrl_if: bundle of scan, collision, geometry and ball-status
// signals between the VGA pipeline and the ball engine.
//   master: drives scan position, launch, collisions, block/paddle geometry;
//           observes colour, ball position/size, state, loss pulse, speed.
//   slave : the ball engine side (mirror of master).
interface ball_motion_ctrl_if #(
    parameter int unsigned N_BLOCKS = 10,
    parameter int unsigned SPD_W    = 3
);
    logic [9:0]          x;
    logic [9:0]          y;
    logic                active_pixels;
    logic                launch;
    logic                collide_paddle;
    logic [N_BLOCKS-1:0] collide_blocks;
    logic [9:0]          block_y;
    logic [9:0]          block_height;
    logic [9:0]          paddle_x;
    logic [9:0]          paddle_width;
    logic [23:0]         vga_color;
    logic [9:0]          ball_x;
    logic [9:0]          ball_y;
    logic [9:0]          ball_size;
    logic [1:0]          state;
    logic                ball_lost;
    logic [SPD_W-1:0]    speed;

    modport master (
        output x, y, active_pixels, launch, collide_paddle, collide_blocks,
               block_y, block_height, paddle_x, paddle_width,
        input  vga_color, ball_x, ball_y, ball_size, state, ball_lost, speed
    );

    modport slave (
        input  x, y, active_pixels, launch, collide_paddle, collide_blocks,
               block_y, block_height, paddle_x, paddle_width,
        output vga_color, ball_x, ball_y, ball_size, state, ball_lost, speed
    );

endinterface

// File: rtl/tick_gen.sv
// tick_gen: free-running divider producing a one-cycle registered tick
// every TICK_DIV clocks.
//   clk  in  system clock
//   rst  in  synchronous active-low reset
//   tick out one-cycle pulse per period
module tick_gen #(
    parameter int unsigned TICK_DIV = 416667
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Wrap counter; tick fires the cycle after the terminal count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) cnt <= '0;
            else                 cnt <= cnt + CNT_W'(1);
            tick <= (cnt == CNT_LAST);
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: ball engine for the brick-breaker pipeline.
// Serve/play/lost state machine, latched paddle/block collisions, wall
// clamping, paddle-angle aiming and ball rendering.
//   clk, rst : clock and synchronous active-low reset
//   bus      : ball_motion_ctrl_if.slave (scan, collisions, geometry in;
//              colour, ball position/size, state, ball_lost, speed out)
// Optional feature: define BALL_SPEEDUP_EN to raise speed by one every
// fourth applied block hit (saturating).
module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned BALL_SIZE  = 20,
    parameter int unsigned TICK_DIV   = 416667,
    parameter int unsigned N_BLOCKS   = 10,
    parameter int unsigned SPD_W      = 3,
    parameter int unsigned INIT_SPEED = 1
) (
    input  logic             clk,
    input  logic             rst,
    ball_motion_ctrl_if.slave bus
);

    localparam int unsigned       HALF     = BALL_SIZE / 2;
    localparam logic [9:0]        X_MAX_U  = 10'(H_RES - BALL_SIZE);
    localparam logic signed [10:0] X_MAX   = 11'(H_RES - BALL_SIZE);
    localparam logic signed [10:0] Y_LOST  = 11'(V_RES);
    localparam logic [9:0]        SERVE_Y  = 10'(V_RES - SERVE_Y_OFS - BALL_SIZE);
    localparam logic [SPD_W-1:0]  SPD_INIT = SPD_W'(INIT_SPEED);
    localparam logic [SPD_W-1:0]  SPD_MAX  = '1;

    logic              tick;
    ball_state_e       st;
    logic [9:0]        bx;
    logic [9:0]        by;
    logic              dir_left;
    logic              dir_down;
    logic [SPD_W-1:0]  spd;
    logic              lost_q;
    logic              hit_paddle;
    logic              hit_block;
    logic              hit_side;
    logic              paddle_prev;
    logic [N_BLOCKS-1:0] blocks_prev;
`ifdef BALL_SPEEDUP_EN
    logic [1:0]        hit_cnt;
`endif

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Serve position: ball centred on paddle, saturated to the screen.
    logic [11:0] serve_sum;
    logic [9:0]  serve_x;
    always_comb begin
        serve_sum = 12'(bus.paddle_x) + 12'(bus.paddle_width >> 1);
        serve_x   = '0;
        if (serve_sum < 12'(HALF))                            serve_x = '0;
        else if (serve_sum - 12'(HALF) > 12'(X_MAX_U))        serve_x = X_MAX_U;
        else                                                  serve_x = 10'(serve_sum - 12'(HALF));
    end

    // Edge-qualified collision events and side detection against the block row.
    logic        paddle_rise;
    logic        block_rise;
    logic [11:0] centre_y;
    logic        side_now;
    logic        left_of_paddle;
    assign paddle_rise    = bus.collide_paddle & ~paddle_prev;
    assign block_rise     = |(bus.collide_blocks & ~blocks_prev);
    assign centre_y       = 12'(by) + 12'(HALF);
    assign side_now       = (centre_y > 12'(bus.block_y) + 12'd5) &&
                            (centre_y + 12'd5 < 12'(bus.block_y) + 12'(bus.block_height));
    assign left_of_paddle = (12'(bx) + 12'(HALF)) <
                            (12'(bus.paddle_x) + 12'(bus.paddle_width >> 1));

    // Play-tick motion: collision response, move, then wall clamping.
    logic signed [10:0] cur_x;
    logic signed [10:0] cur_y;
    logic signed [10:0] step;
    logic signed [10:0] nx;
    logic signed [10:0] ny;
    logic               nl;
    logic               nd;
    always_comb begin
        cur_x = {1'b0, bx};
        cur_y = {1'b0, by};
        step  = 11'(spd);
        nl    = dir_left;
        nd    = dir_down;
        if (hit_paddle) begin
            nd = 1'b0;
            nl = left_of_paddle;
        end else if (hit_block) begin
            nd = 1'b1;
            if (hit_side) nl = ~nl;
        end
        nx = nl ? (cur_x - step) : (cur_x + step);
        ny = nd ? (cur_y + step) : (cur_y - step);
        if (nx < 11'sd0) begin
            nx = 11'sd0;
            nl = 1'b0;
        end else if (nx > X_MAX) begin
            nx = X_MAX;
            nl = 1'b1;
        end
        if (ny < 11'sd0) begin
            ny = 11'sd0;
            nd = 1'b1;
        end
    end

    // State machine, collision latches and ball registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st          <= SERVE;
            spd         <= SPD_INIT;
            dir_left    <= 1'b0;
            dir_down    <= 1'b0;
            bx          <= serve_x;
            by          <= SERVE_Y;
            lost_q      <= 1'b0;
            hit_paddle  <= 1'b0;
            hit_block   <= 1'b0;
            hit_side    <= 1'b0;
            paddle_prev <= 1'b0;
            blocks_prev <= '0;
`ifdef BALL_SPEEDUP_EN
            hit_cnt     <= '0;
`endif
        end else begin
            lost_q      <= 1'b0;
            paddle_prev <= bus.collide_paddle;
            blocks_prev <= bus.collide_blocks;

            // Latches are consumed on a tick; a new edge on that cycle survives it.
            if (st == PLAY) begin
                if (tick) begin
                    hit_paddle <= paddle_rise;
                    hit_block  <= block_rise;
                    hit_side   <= block_rise & side_now;
                end else begin
                    hit_paddle <= hit_paddle | paddle_rise;
                    hit_block  <= hit_block | block_rise;
                    hit_side   <= hit_side | (block_rise & side_now);
                end
            end else begin
                hit_paddle <= 1'b0;
                hit_block  <= 1'b0;
                hit_side   <= 1'b0;
            end

            if (tick) begin
                case (st)
                    SERVE: begin
                        bx <= serve_x;
                        by <= SERVE_Y;
`ifdef BALL_SPEEDUP_EN
                        hit_cnt <= '0;
`endif
                        if (bus.launch) begin
                            st       <= PLAY;
                            dir_left <= 1'b0;
                            dir_down <= 1'b0;
                        end
                    end
                    PLAY: begin
                        bx       <= nx[9:0];
                        by       <= ny[9:0];
                        dir_left <= nl;
                        dir_down <= nd;
                        if (ny >= Y_LOST) begin
                            st     <= LOST;
                            lost_q <= 1'b1;
                        end
`ifdef BALL_SPEEDUP_EN
                        if (hit_block && !hit_paddle) begin
                            hit_cnt <= hit_cnt + 2'd1;
                            if (hit_cnt == 2'd3 && spd != SPD_MAX) spd <= spd + SPD_W'(1);
                        end
`endif
                    end
                    LOST: begin
                        st       <= SERVE;
                        spd      <= SPD_INIT;
                        bx       <= serve_x;
                        by       <= SERVE_Y;
                        dir_left <= 1'b0;
                        dir_down <= 1'b0;
`ifdef BALL_SPEEDUP_EN
                        hit_cnt  <= '0;
`endif
                    end
                    default: st <= SERVE;
                endcase
            end
        end
    end

    // Ball rendering straight from the scan position and ball registers.
    logic in_x;
    logic in_y;
    assign in_x = (11'(bus.x) >= 11'(bx)) && (11'(bus.x) < 11'(bx) + 11'(BALL_SIZE));
    assign in_y = (11'(bus.y) >= 11'(by)) && (11'(bus.y) < 11'(by) + 11'(BALL_SIZE));

    assign bus.vga_color = (bus.active_pixels && in_x && in_y) ? BALL_COLOR : 24'h0;
    assign bus.ball_x    = bx;
    assign bus.ball_y    = by;
    assign bus.ball_size = 10'(BALL_SIZE);
    assign bus.state     = st;
    assign bus.ball_lost = lost_q;
    assign bus.speed     = spd;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: directed self-checking bench for ball_motion_ctrl
// using a short tick period.
module tb_ball_motion_ctrl;

    localparam int unsigned TD = 4;
    localparam int unsigned NB = 10;
    localparam int unsigned SW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_spd;

    ball_motion_ctrl_if #(.N_BLOCKS(NB), .SPD_W(SW)) bus ();

    ball_motion_ctrl #(
        .H_RES(640), .V_RES(480), .BALL_SIZE(20), .TICK_DIV(TD),
        .N_BLOCKS(NB), .SPD_W(SW), .INIT_SPEED(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next tick edge, bounded.
    task automatic wait_tick();
        logic t;
        int   n;
        t = 1'b0;
        n = 0;
        while (!t && n < int'(TD) + 2) begin
            @(negedge clk);
            t = dut.tick;
            @(posedge clk);
            n++;
        end
        #1;
        if (!t) begin
            checks++;
            errors++;
            $error("FAIL tick_timeout observed=0 expected=1");
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic pulse_block(input int idx);
        bus.collide_blocks[idx] = 1'b1;
        @(posedge clk);
        #1;
        bus.collide_blocks[idx] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.x = '0; bus.y = '0; bus.active_pixels = 1'b0; bus.launch = 1'b0;
        bus.collide_paddle = 1'b0; bus.collide_blocks = '0;
        bus.block_y = '0; bus.block_height = '0;
        bus.paddle_x = 10'd300; bus.paddle_width = 10'd80;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(bus.state), 0);
        check("rst_speed", 32'(bus.speed), 1);
        check("rst_lost", 32'(bus.ball_lost), 0);
        check("rst_x", 32'(bus.ball_x), 330);
        check("rst_y", 32'(bus.ball_y), 400);
        check("ball_size", 32'(bus.ball_size), 20);
        rst = 1'b1;

        // Serve tracking
        ticks(3);
        check("serve_state", 32'(bus.state), 0);
        check("serve_x", 32'(bus.ball_x), 330);
        check("serve_y", 32'(bus.ball_y), 400);

        // Rendering edges
        bus.active_pixels = 1'b1; bus.x = 10'd330; bus.y = 10'd400; #1;
        check("vga_top_left", 32'(bus.vga_color), 32'hFFFFFF);
        bus.x = 10'd349; bus.y = 10'd419; #1;
        check("vga_bot_right", 32'(bus.vga_color), 32'hFFFFFF);
        bus.x = 10'd350; #1;
        check("vga_outside", 32'(bus.vga_color), 0);
        bus.x = 10'd340; bus.y = 10'd410; bus.active_pixels = 1'b0; #1;
        check("vga_inactive", 32'(bus.vga_color), 0);

        // Launch then 5 moves up-right
        bus.launch = 1'b1;
        wait_tick();
        bus.launch = 1'b0;
        check("launch_state", 32'(bus.state), 1);
        check("launch_x", 32'(bus.ball_x), 330);
        ticks(5);
        check("play5_x", 32'(bus.ball_x), 335);
        check("play5_y", 32'(bus.ball_y), 395);

        // Paddle and block together: paddle wins, centre left -> up-left
        bus.paddle_x = 10'd400;
        bus.collide_paddle = 1'b1; bus.collide_blocks[4] = 1'b1;
        @(posedge clk); #1;
        bus.collide_paddle = 1'b0; bus.collide_blocks[4] = 1'b0;
        wait_tick();
        check("pad_prio_x", 32'(bus.ball_x), 334);
        check("pad_prio_y", 32'(bus.ball_y), 394);
        wait_tick();
        check("pad_dir_x", 32'(bus.ball_x), 333);
        check("pad_dir_y", 32'(bus.ball_y), 393);

        // Side block hit held over three ticks: applied once
        bus.block_y = 10'd390; bus.block_height = 10'd30;
        bus.collide_blocks[0] = 1'b1;
        wait_tick();
        check("side1_x", 32'(bus.ball_x), 334);
        check("side1_y", 32'(bus.ball_y), 394);
        wait_tick();
        check("side2_y", 32'(bus.ball_y), 395);
        wait_tick();
        check("side3_x", 32'(bus.ball_x), 336);
        check("side3_y", 32'(bus.ball_y), 396);
        bus.collide_blocks[0] = 1'b0;

        // Descend to the bottom
        ticks(83);
        check("pre_lost_state", 32'(bus.state), 1);
        check("pre_lost_x", 32'(bus.ball_x), 419);
        check("pre_lost_y", 32'(bus.ball_y), 479);
        wait_tick();
        check("lost_state", 32'(bus.state), 2);
        check("lost_y", 32'(bus.ball_y), 480);
        check("lost_pulse", 32'(bus.ball_lost), 1);
        @(posedge clk); #1;
        check("lost_pulse_end", 32'(bus.ball_lost), 0);
        wait_tick();
        check("reserve_state", 32'(bus.state), 0);
        check("reserve_speed", 32'(bus.speed), 1);
        wait_tick();
        check("reserve_x", 32'(bus.ball_x), 430);
        check("reserve_y", 32'(bus.ball_y), 400);

        // Serve saturation at both edges
        bus.paddle_x = 10'd0; bus.paddle_width = 10'd0;
        wait_tick();
        check("serve_sat_lo", 32'(bus.ball_x), 0);
        bus.paddle_x = 10'd1000; bus.paddle_width = 10'd80;
        wait_tick();
        check("serve_sat_hi", 32'(bus.ball_x), 620);

        // Right wall clamp
        bus.launch = 1'b1;
        wait_tick();
        bus.launch = 1'b0;
        wait_tick();
        check("rwall_x", 32'(bus.ball_x), 620);
        check("rwall_y", 32'(bus.ball_y), 399);
        wait_tick();
        check("rwall_next_x", 32'(bus.ball_x), 619);

        // Top wall clamp
        ticks(398);
        check("top_pre_x", 32'(bus.ball_x), 221);
        check("top_pre_y", 32'(bus.ball_y), 0);
        wait_tick();
        check("top_clamp_y", 32'(bus.ball_y), 0);
        check("top_clamp_x", 32'(bus.ball_x), 220);
        wait_tick();
        check("top_next_y", 32'(bus.ball_y), 1);

        // Left wall clamp
        ticks(219);
        check("lwall_pre_x", 32'(bus.ball_x), 0);
        check("lwall_pre_y", 32'(bus.ball_y), 220);
        wait_tick();
        check("lwall_x", 32'(bus.ball_x), 0);
        check("lwall_y", 32'(bus.ball_y), 221);
        wait_tick();
        check("lwall_next_x", 32'(bus.ball_x), 1);

        // Four applied block hits (non-side), then lose the ball
        bus.block_y = '0; bus.block_height = '0;
        for (int i = 0; i < 4; i++) begin
            pulse_block(i);
            wait_tick();
        end
`ifdef BALL_SPEEDUP_EN
        exp_spd = 2;
`else
        exp_spd = 1;
`endif
        check("hits_speed", 32'(bus.speed), 32'(exp_spd));
        for (int i = 0; i < 600 && bus.state != 2'd2; i++) wait_tick();
        check("lost2_state", 32'(bus.state), 2);
        check("lost2_pulse", 32'(bus.ball_lost), 1);
        wait_tick();
        check("serve2_state", 32'(bus.state), 0);
        check("serve2_speed", 32'(bus.speed), 1);

        // Reset mid-flight
        bus.launch = 1'b1;
        wait_tick();
        bus.launch = 1'b0;
        ticks(3);
        check("midflight_state", 32'(bus.state), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("mrst_state", 32'(bus.state), 0);
        check("mrst_x", 32'(bus.ball_x), 620);
        check("mrst_y", 32'(bus.ball_y), 400);
        check("mrst_speed", 32'(bus.speed), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
